hwpe_ctrl_uloop_engine: RTL and testbench

Microcode loop engine that consumes the `ucode_t` program and `ctrl_ucode_t` control and produces `flags_ucode_t` for the streamer and address generators. It sits between the control register file, which supplies the microcode and read-only registers, and the datapath. Each `enable` pulse advances a nest of up to `UCODE_NB_LOOPS` loops by one iteration. During that advance it runs the short accumulate/move program attached to the loop level that advanced, then publishes the updated offset registers.

---
 rtl/hwpe_ctrl_package.sv | 51 +++++
 rtl/hwpe_ctrl_uloop_level_sel.sv | 55 +++++
 rtl/hwpe_ctrl_uloop_engine.sv | 166 ++++++++++++++++
 tb/tb_hwpe_ctrl_uloop_engine.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hwpe_ctrl_package.sv
// Shared microcode loop types, constants and the loop state enum for the HWPE control block.
package hwpe_ctrl_package;

    localparam int unsigned UCODE_NB_LOOPS  = 6;
    localparam int unsigned UCODE_NB_REG    = 4;
    localparam int unsigned UCODE_NB_RO_REG = 28;
    localparam int unsigned UCODE_CNT_WIDTH = 12;
    localparam int unsigned UCODE_LENGTH    = 16;
    localparam int unsigned UCODE_LOOP_W    = $clog2(UCODE_NB_LOOPS);
    localparam int unsigned UCODE_ADDR_W    = $clog2(UCODE_LENGTH);
    localparam int unsigned UCODE_OPS_W     = UCODE_ADDR_W + 1;

    typedef struct packed {
        logic       op_sel;
        logic [4:0] a;
        logic [4:0] b;
    } ucode_op_t;

    typedef struct packed {
        logic [UCODE_ADDR_W-1:0] ucode_addr;
        logic [UCODE_OPS_W-1:0]  nb_ops;
    } ucode_loop_t;

    typedef struct packed {
        ucode_loop_t [UCODE_NB_LOOPS-1:0]                      loops;
        ucode_op_t   [UCODE_LENGTH-1:0]                        code;
        logic        [UCODE_NB_LOOPS-1:0][UCODE_CNT_WIDTH-1:0] range;
    } ucode_t;

    typedef struct packed {
        logic                    enable;
        logic                    clear;
        logic [UCODE_LOOP_W-1:0] accum_loop;
    } ctrl_ucode_t;

    typedef struct packed {
        logic                                           done;
        logic                                           valid;
        logic [UCODE_NB_REG-1:0][31:0]                  offs;
        logic [UCODE_NB_LOOPS-1:0][UCODE_CNT_WIDTH-1:0] idx;
        logic                                           accum;
    } flags_ucode_t;

    typedef enum logic [1:0] {StIdle, StFirst, StExec, StTerm} uloop_state_t;

    // A programmed range of 0 behaves as a single iteration.
    function automatic logic [UCODE_CNT_WIDTH-1:0] eff_range(input logic [UCODE_CNT_WIDTH-1:0] r);
        return (r == '0) ? UCODE_CNT_WIDTH'(1) : r;
    endfunction

endpackage

// File: rtl/hwpe_ctrl_uloop_level_sel.sv
// Picks the innermost loop level that can still advance, the mask of inner levels to
// wrap to zero, and whether the current or the next iteration is the last one.
module hwpe_ctrl_uloop_level_sel
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned NB_LOOPS  = UCODE_NB_LOOPS,
    parameter int unsigned CNT_WIDTH = UCODE_CNT_WIDTH
) (
    input  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] idx_i,
    input  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] range_i,
    output logic [UCODE_LOOP_W-1:0]            level_o,
    output logic [NB_LOOPS-1:0]                zero_mask_o,
    output logic                               term_now_o,
    output logic                               term_next_o
);

    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] last;
    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] idx_next;
    logic                               found;

    always_comb begin
        last        = '0;
        idx_next    = '0;
        found       = 1'b0;
        level_o     = '0;
        zero_mask_o = '0;
        term_now_o  = 1'b1;
        term_next_o = 1'b1;
        for (int l = 0; l < NB_LOOPS; l++) begin
            last[l] = eff_range(range_i[l]) - CNT_WIDTH'(1);
            if (idx_i[l] != last[l]) term_now_o = 1'b0;
            if (!found && (idx_i[l] < last[l])) begin
                found   = 1'b1;
                level_o = UCODE_LOOP_W'(l);
            end
        end
        // Evaluate the iteration that stepping level_o would produce.
        for (int l = 0; l < NB_LOOPS; l++) begin
            if (l < int'(level_o)) begin
                zero_mask_o[l] = 1'b1;
                idx_next[l]    = '0;
            end else if (l == int'(level_o)) begin
                idx_next[l] = idx_i[l] + CNT_WIDTH'(1);
            end else begin
                idx_next[l] = idx_i[l];
            end
            if (idx_next[l] != last[l]) term_next_o = 1'b0;
        end
        if (!found) begin
            zero_mask_o = '0;
            term_next_o = 1'b0;
        end
    end

endmodule

// File: rtl/hwpe_ctrl_uloop_engine.sv
// Microcode loop engine: each enable advances the loop nest and runs the advancing level's ops.
// Optional HWPE_CTRL_ULOOP_PEND_EN latches one enable seen while busy and replays it in IDLE.
module hwpe_ctrl_uloop_engine
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned NB_LOOPS  = UCODE_NB_LOOPS,
    parameter int unsigned NB_REG    = UCODE_NB_REG,
    parameter int unsigned NB_RO_REG = UCODE_NB_RO_REG,
    parameter int unsigned CNT_WIDTH = UCODE_CNT_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  ctrl_ucode_t                 ctrl_i,
    input  ucode_t                      ucode_i,
    input  logic [NB_RO_REG-1:0][31:0]  registers_read_i,
    output flags_ucode_t                flags_o
);

    uloop_state_t            state_q;
    flags_ucode_t            flags_q;
    logic                    first_q;
    logic                    term_q;
    logic [UCODE_ADDR_W-1:0] op_ptr_q;
    logic [UCODE_OPS_W-1:0]  ops_left_q;
`ifdef HWPE_CTRL_ULOOP_PEND_EN
    logic                    pend_q;
`endif

    logic                    step_req;
    logic [UCODE_LOOP_W-1:0] level;
    logic [NB_LOOPS-1:0]     zero_mask;
    logic                    term_now;
    logic                    term_next;
    ucode_loop_t             loop_sel;
    ucode_op_t               op;
    logic [31:0]             src;
    logic [31:0]             cur;
    logic [31:0]             dst_val;
    logic                    unused_a_hi;

    hwpe_ctrl_uloop_level_sel #(
        .NB_LOOPS  (NB_LOOPS),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_level_sel (
        .idx_i       (flags_q.idx),
        .range_i     (ucode_i.range),
        .level_o     (level),
        .zero_mask_o (zero_mask),
        .term_now_o  (term_now),
        .term_next_o (term_next)
    );

`ifdef HWPE_CTRL_ULOOP_PEND_EN
    assign step_req = ctrl_i.enable | pend_q;
`else
    assign step_req = ctrl_i.enable;
`endif

    assign unused_a_hi = ^op.a[4:2];
    assign flags_o     = flags_q;

    always_comb begin
        loop_sel = ucode_i.loops[level];
        op       = ucode_i.code[op_ptr_q];
        src      = '0;
        cur      = '0;
        for (int r = 0; r < NB_REG; r++) begin
            if (int'(op.b) == r) src = flags_q.offs[r];
            if (int'(op.a[1:0]) == r) cur = flags_q.offs[r];
        end
        for (int r = 0; r < NB_RO_REG; r++) begin
            if (int'(op.b) == r + int'(NB_REG)) src = registers_read_i[r];
        end
        dst_val = op.op_sel ? (cur + src) : src;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            flags_q    <= '0;
            first_q    <= 1'b1;
            term_q     <= 1'b0;
            op_ptr_q   <= '0;
            ops_left_q <= '0;
`ifdef HWPE_CTRL_ULOOP_PEND_EN
            pend_q     <= 1'b0;
`endif
        end else if (ctrl_i.clear) begin
            state_q    <= StIdle;
            flags_q    <= '0;
            first_q    <= 1'b1;
            term_q     <= 1'b0;
            op_ptr_q   <= '0;
            ops_left_q <= '0;
`ifdef HWPE_CTRL_ULOOP_PEND_EN
            pend_q     <= 1'b0;
`endif
        end else begin
            flags_q.valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (step_req) begin
`ifdef HWPE_CTRL_ULOOP_PEND_EN
                        pend_q <= 1'b0;
`endif
                        if (first_q) begin
                            first_q       <= 1'b0;
                            flags_q.valid <= 1'b1;
                            flags_q.accum <= 1'b0;
                            flags_q.done  <= term_now;
                            state_q       <= StFirst;
                        end else begin
                            for (int l = 0; l < NB_LOOPS; l++) begin
                                if (zero_mask[l]) begin
                                    flags_q.idx[l] <= '0;
                                end else if (l == int'(level)) begin
                                    flags_q.idx[l] <= flags_q.idx[l] + CNT_WIDTH'(1);
                                end
                            end
                            flags_q.accum <= (level <= ctrl_i.accum_loop);
                            op_ptr_q      <= loop_sel.ucode_addr;
                            ops_left_q    <= loop_sel.nb_ops;
                            term_q        <= term_next;
                            // Empty programs publish straight away; EXEC then only retires.
                            if (loop_sel.nb_ops == '0) begin
                                flags_q.valid <= 1'b1;
                                flags_q.done  <= term_next;
                            end
                            state_q <= StExec;
                        end
                    end
                end
                StFirst: begin
`ifdef HWPE_CTRL_ULOOP_PEND_EN
                    if (ctrl_i.enable) pend_q <= 1'b1;
`endif
                    state_q <= flags_q.done ? StTerm : StIdle;
                end
                StExec: begin
`ifdef HWPE_CTRL_ULOOP_PEND_EN
                    if (ctrl_i.enable) pend_q <= 1'b1;
`endif
                    if (ops_left_q == '0) begin
                        state_q <= term_q ? StTerm : StIdle;
                    end else begin
                        for (int r = 0; r < NB_REG; r++) begin
                            if (int'(op.a[1:0]) == r) flags_q.offs[r] <= dst_val;
                        end
                        op_ptr_q   <= op_ptr_q + UCODE_ADDR_W'(1);
                        ops_left_q <= ops_left_q - UCODE_OPS_W'(1);
                        if (ops_left_q == UCODE_OPS_W'(1)) begin
                            flags_q.valid <= 1'b1;
                            flags_q.done  <= term_q;
                            state_q       <= term_q ? StTerm : StIdle;
                        end
                    end
                end
                StTerm: begin
                    state_q <= StTerm;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_hwpe_ctrl_uloop_engine.sv
// Directed self-checking bench for hwpe_ctrl_uloop_engine with hand-computed expectations.
module tb_hwpe_ctrl_uloop_engine;
    import hwpe_ctrl_package::*;

    logic                              clk = 1'b0;
    logic                              rst_n;
    ctrl_ucode_t                       ctrl;
    ucode_t                            ucode;
    logic [UCODE_NB_RO_REG-1:0][31:0]  ro;
    flags_ucode_t                      flags;

    int n_tests = 0;
    int n_fail  = 0;

    // Two-level program: ranges {2,3}; loop0 adds ro[0]=4 to offs0,
    // loop1 zeroes offs0 from offs3 and adds ro[1]=100 to offs1.
    int exp_o0  [6] = '{0, 4, 0, 4, 0, 4};
    int exp_o1  [6] = '{0, 0, 100, 100, 200, 200};
    int exp_i0  [6] = '{0, 1, 0, 1, 0, 1};
    int exp_i1  [6] = '{0, 0, 1, 1, 2, 2};
    int exp_lat [6] = '{1, 2, 3, 2, 3, 2};
    int exp_lvl [6] = '{0, 0, 1, 0, 1, 0};

    always #5 clk = ~clk;

    hwpe_ctrl_uloop_engine dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .ctrl_i           (ctrl),
        .ucode_i          (ucode),
        .registers_read_i (ro),
        .flags_o          (flags)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        ctrl.clear = 1'b1;
        @(negedge clk);
        ctrl.clear = 1'b0;
    endtask

    task automatic do_step(output int lat);
        @(negedge clk);
        ctrl.enable = 1'b1;
        @(negedge clk);
        ctrl.enable = 1'b0;
        lat = 1;
        while (!flags.valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_program(input logic [2:0] al);
        int   lat;
        logic e_acc;
        ctrl.accum_loop = al;
        do_clear();
        for (int s = 0; s < 6; s++) begin
            do_step(lat);
            e_acc = (s == 0) ? 1'b0 : (exp_lvl[s] <= int'(al));
            check_eq($sformatf("lat_al%0d_s%0d", al, s + 1), 64'(lat), 64'(exp_lat[s]));
            check_eq($sformatf("valid_al%0d_s%0d", al, s + 1), 64'(flags.valid), 64'd1);
            check_eq($sformatf("offs0_al%0d_s%0d", al, s + 1), 64'(flags.offs[0]), 64'(exp_o0[s]));
            check_eq($sformatf("offs1_al%0d_s%0d", al, s + 1), 64'(flags.offs[1]), 64'(exp_o1[s]));
            check_eq($sformatf("idx0_al%0d_s%0d", al, s + 1), 64'(flags.idx[0]), 64'(exp_i0[s]));
            check_eq($sformatf("idx1_al%0d_s%0d", al, s + 1), 64'(flags.idx[1]), 64'(exp_i1[s]));
            check_eq($sformatf("done_al%0d_s%0d", al, s + 1), 64'(flags.done), (s == 5) ? 64'd1 : 64'd0);
            check_eq($sformatf("accum_al%0d_s%0d", al, s + 1), 64'(flags.accum), 64'(e_acc));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   lat;
        int   nval;
        logic seen;

        rst_n = 1'b0;
        ctrl  = '0;
        ucode = '0;
        ro    = '0;
        ro[0] = 32'd4;
        ro[1] = 32'd100;
        ucode.range[0] = 12'd2;
        ucode.range[1] = 12'd3;
        ucode.loops[0].ucode_addr = 4'd0;
        ucode.loops[0].nb_ops     = 5'd1;
        ucode.loops[1].ucode_addr = 4'd1;
        ucode.loops[1].nb_ops     = 5'd2;
        ucode.code[0].op_sel = 1'b1;
        ucode.code[0].a      = 5'd0;
        ucode.code[0].b      = 5'd4;
        ucode.code[1].op_sel = 1'b0;
        ucode.code[1].a      = 5'd0;
        ucode.code[1].b      = 5'd3;
        ucode.code[2].op_sel = 1'b1;
        ucode.code[2].a      = 5'd1;
        ucode.code[2].b      = 5'd5;

        repeat (2) @(negedge clk);
        check_eq("rst_valid", 64'(flags.valid), 64'd0);
        check_eq("rst_done", 64'(flags.done), 64'd0);
        check_eq("rst_accum", 64'(flags.accum), 64'd0);
        check_eq("rst_offs0", 64'(flags.offs[0]), 64'd0);
        check_eq("rst_idx0", 64'(flags.idx[0]), 64'd0);
        rst_n = 1'b1;

        // Full nest with accum_loop=0, then done must stay sticky.
        run_program(3'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ctrl.enable = 1'b1;
            @(negedge clk);
            ctrl.enable = 1'b0;
            seen = 1'b0;
            repeat (4) begin
                if (flags.valid) seen = 1'b1;
                @(negedge clk);
            end
            check_eq($sformatf("term_novalid_%0d", k), 64'(seen), 64'd0);
        end
        check_eq("term_done", 64'(flags.done), 64'd1);
        check_eq("term_offs0", 64'(flags.offs[0]), 64'd4);
        check_eq("term_offs1", 64'(flags.offs[1]), 64'd200);
        check_eq("term_idx1", 64'(flags.idx[1]), 64'd2);

        run_program(3'd1);

        // Clear during EXEC of step 3 aborts it.
        do_clear();
        do_step(lat);
        do_step(lat);
        @(negedge clk);
        ctrl.enable = 1'b1;
        @(negedge clk);
        ctrl.enable = 1'b0;
        ctrl.clear  = 1'b1;
        @(negedge clk);
        ctrl.clear = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            if (flags.valid) seen = 1'b1;
            @(negedge clk);
        end
        check_eq("clr_novalid", 64'(seen), 64'd0);
        check_eq("clr_offs0", 64'(flags.offs[0]), 64'd0);
        check_eq("clr_idx0", 64'(flags.idx[0]), 64'd0);
        do_step(lat);
        check_eq("clr_s1_lat", 64'(lat), 64'd1);
        check_eq("clr_s1_valid", 64'(flags.valid), 64'd1);
        check_eq("clr_s1_offs0", 64'(flags.offs[0]), 64'd0);
        check_eq("clr_s1_offs1", 64'(flags.offs[1]), 64'd0);
        check_eq("clr_s1_idx1", 64'(flags.idx[1]), 64'd0);
        check_eq("clr_s1_accum", 64'(flags.accum), 64'd0);

        // Enable held into EXEC of step 3.
        do_step(lat);
        check_eq("pend_s2_lat", 64'(lat), 64'd2);
        @(negedge clk);
        ctrl.enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ctrl.enable = 1'b0;
        nval = 0;
        repeat (8) begin
            if (flags.valid) nval++;
            @(negedge clk);
        end
`ifdef HWPE_CTRL_ULOOP_PEND_EN
        check_eq("pend_nvalid", 64'(nval), 64'd2);
        check_eq("pend_offs0", 64'(flags.offs[0]), 64'd4);
        check_eq("pend_idx0", 64'(flags.idx[0]), 64'd1);
`else
        check_eq("pend_nvalid", 64'(nval), 64'd1);
        check_eq("pend_offs0", 64'(flags.offs[0]), 64'd0);
        check_eq("pend_idx0", 64'(flags.idx[0]), 64'd0);
`endif
        check_eq("pend_offs1", 64'(flags.offs[1]), 64'd100);

        // Asynchronous reset in the middle of EXEC.
        do_clear();
        do_step(lat);
        do_step(lat);
        check_eq("arst_pre_offs0", 64'(flags.offs[0]), 64'd4);
        @(negedge clk);
        ctrl.enable = 1'b1;
        @(negedge clk);
        ctrl.enable = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_offs0", 64'(flags.offs[0]), 64'd0);
        check_eq("arst_idx0", 64'(flags.idx[0]), 64'd0);
        check_eq("arst_valid", 64'(flags.valid), 64'd0);
        check_eq("arst_done", 64'(flags.done), 64'd0);
        check_eq("arst_accum", 64'(flags.accum), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
